pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL have ports: CLK  in  1  rising-edge clock; RST  in  1  reset.
REQ-003 SHALL have ports: ihit  in  1  instr fetch done; dhit  in  1  data access done; dREN_mem, dWEN_mem  in  1  mem-stage access pending.
REQ-004 SHALL have ports: branch_mem  in  1  taken branch resolved in mem; jump_mem  in  1  jump/jr in mem; halt_wb  in  1  halt reached WB.
REQ-005 SHALL have ports: dREN_ex  in  1  load in ex; regWSEL_ex  in  5  ex dest reg; rs_dec, rt_dec  in  5  dec source regs.
REQ-006 SHALL have ports: fd_state, de_state, em_state, mw_state  out  2  latch commands (00 STALL, 01 ENABLE, 10 NOP, 11 FLUSH); pc_en  out  1  PC load enable.
REQ-007 SHALL have ports: ctrl_st  out  2  FSM state; stall_cnt, flush_cnt  out  16  perf counters; halted  out  1.

Function
REQ-008 SHALL implement FSM states RUN (00), DWAIT (01), HALT (10); 11 unused, decodes as RUN.
REQ-009 Outputs SHALL be combinational from FSM state and current inputs; the latch acts on the next CLK edge.
REQ-010 Case priority, highest first: HALT state or halt_wb, then memwait, then redirect, then loaduse, then fetchwait, then normal.
REQ-011 halt: all four = STALL; pc_en=0; next state HALT, held until RST.
REQ-012 memwait = (dREN_mem|dWEN_mem)&!dhit: fd/de/em=STALL; mw=NOP; pc_en=0; next state DWAIT.
REQ-013 DWAIT SHALL exit to RUN on the dhit cycle; that cycle is evaluated with the lower-priority cases.
REQ-014 redirect = branch_mem|jump_mem, evaluated only when not memwait: fd/de/em=FLUSH; mw=ENABLE; pc_en=1, regardless of ihit.
REQ-015 loaduse = dREN_ex & regWSEL_ex!=0 & (regWSEL_ex==rs_dec | regWSEL_ex==rt_dec): pc_en=0; fd=STALL; de=NOP; em/mw=ENABLE.
REQ-016 fetchwait = !ihit: pc_en=0; fd=NOP; de/em/mw=ENABLE.
REQ-017 normal: all four = ENABLE; pc_en=1.
REQ-018 Register 0 SHALL never trigger loaduse.
REQ-019 stall_cnt SHALL increment each cycle with pc_en=0 in state RUN/DWAIT; flush_cnt SHALL increment each redirect cycle; both saturate at 16'hFFFF.
REQ-020 halted SHALL be 1 exactly when state=HALT.
REQ-021 Neither counter SHALL change in HALT.

Reset
REQ-022 RST high at a CLK edge SHALL set state=RUN and stall_cnt=flush_cnt=0, overriding all inputs.
REQ-023 While RST is high, outputs SHALL be fd/de/em/mw=FLUSH and pc_en=0.
REQ-024 RST mid-DWAIT or in HALT SHALL return to RUN on the next edge.

Structure
REQ-025 pipe_state_t (STALL/ENABLE/NOP/FLUSH encoding) and ctrl_state_t SHALL live in cpu_types_pkg; pipeline_if SHALL import them rather than declare them.
REQ-026 A combinational sub-module load_use_detect SHALL compute the loaduse condition (REQ-015, REQ-018).
REQ-027 Outputs SHALL connect to the fd_state/de_state/em_state/mw_state signals of pipeline_if.

Verification
REQ-028 dREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> ctrl_st=DWAIT for 3 cycles; fd/de/em=00, mw=10, pc_en=0; on the 4th cycle all 01; stall_cnt=3.
REQ-029 branch_mem=1, ihit=0 for 1 cycle -> fd/de/em=11, mw=01, pc_en=1; flush_cnt=1.
REQ-030 dREN_ex=1, regWSEL_ex=5, rt_dec=5 -> pc_en=0, fd=00, de=10, em=01; repeat with regWSEL_ex=0, rs_dec=0 -> all 01.
REQ-031 dWEN_mem=1, dhit=0, branch_mem=1 -> memwait outputs; on dhit=1 -> redirect outputs that cycle.
REQ-032 halt_wb=1 for 1 cycle -> halted=1 persisting, all states 00; RST=1 -> RUN, counters 0.
REQ-033 Force 70000 stall cycles -> stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: pipeline latch commands, control FSM states,
// the per-cycle command bundle and small helpers.
package cpu_types_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PIPE_W = 2;

   // Command applied by a pipeline latch on the next clock edge.
   typedef enum logic [PIPE_W-1:0] {
      PIPE_STALL  = 2'b00,
      PIPE_ENABLE = 2'b01,
      PIPE_NOP    = 2'b10,
      PIPE_FLUSH  = 2'b11
   } pipe_state_t;

   // Control FSM state; 2'b11 is unused and behaves as ST_RUN.
   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_DWAIT = 2'b01,
      ST_HALT  = 2'b10
   } ctrl_state_t;

   // One cycle's worth of latch commands plus the PC load enable.
   typedef struct packed {
      pipe_state_t fd;
      pipe_state_t de;
      pipe_state_t em;
      pipe_state_t mw;
      logic        pc_en;
   } pipe_cmd_t;

   // Build a command bundle in fd/de/em/mw order.
   function automatic pipe_cmd_t mk_cmd(input pipe_state_t fd,
                                        input pipe_state_t de,
                                        input pipe_state_t em,
                                        input pipe_state_t mw,
                                        input logic        pc_en);
      pipe_cmd_t c;
      c.fd    = fd;
      c.de    = de;
      c.em    = em;
      c.mw    = mw;
      c.pc_en = pc_en;
      return c;
   endfunction

   // Saturating increment for the performance counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pipeline_if.sv
// Pipeline latch control bundle shared between the controller and the
// pipeline registers.
//   fd_state/de_state/em_state/mw_state : latch commands
//   pc_en                                : PC load enable
interface pipeline_if;
   import cpu_types_pkg::*;

   pipe_state_t fd_state;
   pipe_state_t de_state;
   pipe_state_t em_state;
   pipe_state_t mw_state;
   logic        pc_en;

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags a load in EX whose destination register
// is a source of the instruction in decode. Register 0 never matches.
//   dREN_ex     : load in EX
//   regWSEL_ex  : EX destination register
//   rs_dec      : decode source register rs
//   rt_dec      : decode source register rt
//   load_use_c  : hazard present (combinational)
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic             dREN_ex,
   input  logic [REG_W-1:0] regWSEL_ex,
   input  logic [REG_W-1:0] rs_dec,
   input  logic [REG_W-1:0] rt_dec,
   output logic             load_use_c
);

   logic dest_valid;
   logic src_match;

   // $zero is hardwired, so a load targeting it creates no dependency.
   assign dest_valid = (regWSEL_ex != '0);
   assign src_match  = (regWSEL_ex == rs_dec) | (regWSEL_ex == rt_dec);
   assign load_use_c = dREN_ex & dest_valid & src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: issues per-cycle latch commands and PC
// enable from the control FSM and the current hazard inputs, and keeps
// saturating stall/flush performance counters.
//   CLK, RST                   : clock, synchronous active-high reset
//   ihit, dhit                 : fetch / data access complete
//   dREN_mem, dWEN_mem         : memory-stage access pending
//   branch_mem, jump_mem       : control-flow redirect resolved in MEM
//   halt_wb                    : halt reached WB
//   dREN_ex, regWSEL_ex        : load in EX and its destination
//   rs_dec, rt_dec             : decode source registers
//   fd/de/em/mw_state, pc_en   : latch commands and PC enable (combinational)
//   ctrl_st, halted            : FSM state and halt flag
//   stall_cnt, flush_cnt       : saturating performance counters
module pipeline_ctrl
   import cpu_types_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                ihit,
   input  logic                dhit,
   input  logic                dREN_mem,
   input  logic                dWEN_mem,
   input  logic                branch_mem,
   input  logic                jump_mem,
   input  logic                halt_wb,
   input  logic                dREN_ex,
   input  logic [REG_W-1:0]    regWSEL_ex,
   input  logic [REG_W-1:0]    rs_dec,
   input  logic [REG_W-1:0]    rt_dec,
   output logic [PIPE_W-1:0]   fd_state,
   output logic [PIPE_W-1:0]   de_state,
   output logic [PIPE_W-1:0]   em_state,
   output logic [PIPE_W-1:0]   mw_state,
   output logic                pc_en,
   output logic [1:0]          ctrl_st,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt,
   output logic                halted
);

   ctrl_state_t state;
   ctrl_state_t next_state;
   pipe_cmd_t   cmd;
   logic        redirect;
   logic        mem_wait;
   logic        redirect_req;
   logic        load_use;

   pipeline_if pif ();

   load_use_detect u_load_use_detect (
      .dREN_ex    (dREN_ex),
      .regWSEL_ex (regWSEL_ex),
      .rs_dec     (rs_dec),
      .rt_dec     (rt_dec),
      .load_use_c (load_use)
   );

   assign mem_wait     = (dREN_mem | dWEN_mem) & ~dhit;
   assign redirect_req = branch_mem | jump_mem;

   // State register and performance counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= next_state;
         if ((state != ST_HALT) && !cmd.pc_en)
            stall_cnt <= sat_inc(stall_cnt);
         if (redirect)
            flush_cnt <= sat_inc(flush_cnt);
      end
   end

   // Next state and latch commands, highest-priority case first.
   // The DWAIT exit cycle (dhit seen) drops through to the lower cases.
   always_comb begin
      next_state = state;
      cmd        = mk_cmd(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
      redirect   = 1'b0;

      if (RST) begin
         cmd        = mk_cmd(PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, 1'b0);
         next_state = ST_RUN;
      end else if ((state == ST_HALT) || halt_wb) begin
         cmd        = mk_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
         next_state = ST_HALT;
      end else if (mem_wait) begin
         // MEM result is not ready: freeze upstream, bubble into WB.
         cmd        = mk_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0);
         next_state = ST_DWAIT;
      end else begin
         next_state = ST_RUN;
         if (redirect_req) begin
            // Wrong-path instructions are squashed; the PC loads the target
            // even if the current fetch is still outstanding.
            cmd      = mk_cmd(PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_ENABLE, 1'b1);
            redirect = 1'b1;
         end else if (load_use) begin
            cmd = mk_cmd(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
         end else if (!ihit) begin
            cmd = mk_cmd(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
         end
      end
   end

   assign pif.fd_state = cmd.fd;
   assign pif.de_state = cmd.de;
   assign pif.em_state = cmd.em;
   assign pif.mw_state = cmd.mw;
   assign pif.pc_en    = cmd.pc_en;

   assign fd_state = pif.fd_state;
   assign de_state = pif.de_state;
   assign em_state = pif.em_state;
   assign mw_state = pif.mw_state;
   assign pc_en    = pif.pc_en;

   assign ctrl_st = state;
   assign halted  = (state == ST_HALT);

endmodule
